bcd_sevenseg_scan: RTL and testbench
====================================

// Module: bcd_sevenseg_scan
// PURPOSE
//   Time-multiplexed driver for an 8-digit common-anode 7-segment display.
//   Consumes the 32-bit packed BCD stopwatch value {HH,MM,SS,cc} from the counter stage.
//   Scans one digit per refresh slot and adds decimal points (HH.MM.SS.cc).
//   Also provides leading-zero blanking, invalid-BCD indication and tear-free frame snapshots.
// PARAMETERS
//   REFRESH_DIV   100000       clk cycles per digit slot (>= BLANK_CYCLES+2)
//   BLANK_CYCLES  4            anti-ghost cycles at start of each slot, all anodes off
//   DP_MASK       8'b0101_0100 dp lit on digit i when DP_MASK[i]=1
//   BLANK_LEADING 1            1: blank leading zeros in digits 7..3
//   AN_ACTIVE_LOW 1            1: anode asserted = 0
//   SEG_ACTIVE_LOW 1           1: segment/dp lit = 0
// PORTS
//   clk         in   1   system clock
//   reset       in   1   synchronous, active-high reset
//   data        in   32  packed BCD; nibble i = digit i (i=0 is 1/100 s, LSB)
//   display_en  in   1   0: all anodes off; scanning continues
//   an          out  8   anode enables; an[i] drives digit i
//   seg         out  7   {g,f,e,d,c,b,a}
//   dp          out  1   decimal point of the active digit
//   frame_tick  out  1   1-cycle pulse at each frame boundary (slot 7 -> slot 0)
// BEHAVIOUR
//   Reset: cnt=0, idx=0, shadow=0, all outputs registered.
//   Reset output values: an all inactive (8'hFF when active-low), seg all off (7'h7F),
//     dp off (1), frame_tick=0.
//   Reset asserted mid-frame: outputs return to reset values on the next edge; the scan
//     restarts at slot 0.
//   Prescaler: cnt counts 0..REFRESH_DIV-1 and wraps. slot_tick=1 when cnt==REFRESH_DIV-1.
//   Digit index: idx increments mod 8 on slot_tick.
//   Frame boundary = slot_tick while idx==7. On that edge:
//     - shadow<=data
//     - frame_tick<=1 for exactly one cycle
//     - idx<=0
//   Display content: all decode uses shadow only. A change on data mid-frame is not visible
//     until the frame after the next boundary.
//   Decode, active-high {g..a}:
//     0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
//     A..F (invalid) = 40 (dash)
//   Invalid nibbles are never blanked.
//   Leading blank (BLANK_LEADING=1):
//     - digit k in 7..3 is blanked iff shadow nibbles k..7 are all 0
//     - digits 2..0 are never blanked, so 0 displays as 0.00
//     - blanked digit: anode inactive for the whole slot, seg/dp off
//   Anode: an[idx] is asserted only when all of the following hold:
//     - cnt >= BLANK_CYCLES
//     - display_en=1
//     - digit idx is not blanked
//     Otherwise all anodes are inactive.
//   Latency: an/seg/dp are registered, 1 cycle after cnt/idx/shadow/display_en.
//   seg/dp always carry the pattern of digit idx, gated off when the anode is off.
//   dp lit iff DP_MASK[idx] and the anode is asserted.
//   Polarity: invert an when AN_ACTIVE_LOW=1; invert seg and dp when SEG_ACTIVE_LOW=1.
//   Counters free-run regardless of display_en; frame_tick keeps pulsing.
// TESTING (REFRESH_DIV=8, BLANK_CYCLES=2, other parameters at default)
//   1. Hold reset 3 cycles -> an=FF, seg=7F, dp=1, frame_tick=0. Release reset ->
//      first frame_tick 64 cycles later; period 64 cycles after that.
//   2. data=32'h1234_5678, then one frame -> slot 0: an=FE, seg=00 ('8').
//      Slot 7: an=7F, seg=79 ('1'). dp=0 only in slots 2,4,6.
//      Anodes off for the first 2 cycles (+1 latency) of each slot.
//   3. data=32'h0000_0012, run 2 frames -> an[7:3] never asserted.
//      Digits 2,1,0 show seg=40,79,24 ('0','1','2'); dp lit on digit 2.
//   4. Change data 32'h11 -> 32'h99 at slot 3 of a frame -> remainder of that frame still
//      shows 11. Frame after next frame_tick shows 99.
//   5. data nibble 0 = 4'hA -> slot 0 seg=3F (dash, active-low), an=FE.
//      display_en=0 -> an=FF within 1 cycle; frame_tick period unchanged.
//   6. Assert reset at slot 5, cnt=4 -> next edge: outputs at reset values.
//      After release, idx=0 and frame_tick occurs 64 cycles later.

Source files
------------

// File: rtl/bcd_sevenseg_scan.sv
// bcd_sevenseg_scan: time-multiplexed driver for an 8-digit common-anode
// 7-segment display showing a packed BCD stopwatch value HH.MM.SS.cc.
// One digit is lit per refresh slot. The first BLANK_CYCLES of every slot keep
// all anodes off so the previous digit's segments cannot ghost onto the next.
// The displayed value is a snapshot taken at each frame boundary, so a frame
// never mixes digits from two different counter values.
//
// Handshake: none. data is sampled only on the frame-boundary edge, and
// frame_tick is an unqualified one-cycle pulse that needs no acknowledge.
module bcd_sevenseg_scan #(
    parameter int         REFRESH_DIV    = 100000,
    parameter int         BLANK_CYCLES   = 4,
    parameter logic [7:0] DP_MASK        = 8'b0101_0100,
    parameter bit         BLANK_LEADING  = 1'b1,
    parameter bit         AN_ACTIVE_LOW  = 1'b1,
    parameter bit         SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data,
    input  logic        display_en,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int            CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [31:0]   shadow;

    logic          slot_tick;
    logic [3:0]    nibble;
    logic [7:0]    upper_zero;
    logic [7:0]    blank;
    logic [6:0]    pattern;
    logic          an_on;
    logic [7:0]    an_hi;
    logic [6:0]    seg_hi;
    logic          dp_hi;

    assign slot_tick = (cnt == CNT_MAX);
    assign nibble    = shadow[{idx, 2'b00} +: 4];

    // upper_zero[k] is set when shadow nibbles k..7 are all zero; only the
    // top five digits may be blanked so the value always reads at least 0.00.
    always_comb begin
        upper_zero    = '0;
        upper_zero[7] = (shadow[31:28] == 4'h0);
        for (int k = 6; k >= 0; k--) begin
            upper_zero[k] = upper_zero[k+1] && (shadow[4*k +: 4] == 4'h0);
        end
    end

    assign blank = BLANK_LEADING ? {upper_zero[7:3], 3'b000} : 8'h00;

    // BCD to active-high {g..a}; nibbles A..F are not BCD and show a dash.
    always_comb begin
        pattern = 7'h40;
        case (nibble)
            4'd0: pattern = 7'h3F;
            4'd1: pattern = 7'h06;
            4'd2: pattern = 7'h5B;
            4'd3: pattern = 7'h4F;
            4'd4: pattern = 7'h66;
            4'd5: pattern = 7'h6D;
            4'd6: pattern = 7'h7D;
            4'd7: pattern = 7'h07;
            4'd8: pattern = 7'h7F;
            4'd9: pattern = 7'h6F;
            default: pattern = 7'h40;
        endcase
    end

    // Active-high view of the next outputs; seg/dp are gated with the anode.
    always_comb begin
        an_on  = (cnt >= CNT_BLANK) && display_en && !blank[idx];
        an_hi  = an_on ? (8'h01 << idx) : 8'h00;
        seg_hi = an_on ? pattern : 7'h00;
        dp_hi  = an_on && DP_MASK[idx];
    end

    // Prescaler, digit index and frame snapshot; counters free-run regardless
    // of display_en so frame_tick keeps its period.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= 3'd0;
            shadow     <= 32'h0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (slot_tick) begin
                cnt <= '0;
                idx <= idx + 3'd1;
                if (idx == 3'd7) begin
                    shadow     <= data;
                    frame_tick <= 1'b1;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Registered pin drivers with board polarity applied.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= {8{AN_ACTIVE_LOW}};
            seg <= {7{SEG_ACTIVE_LOW}};
            dp  <= SEG_ACTIVE_LOW;
        end else begin
            an  <= AN_ACTIVE_LOW  ? ~an_hi  : an_hi;
            seg <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
            dp  <= SEG_ACTIVE_LOW ? ~dp_hi  : dp_hi;
        end
    end

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Directed testbench for bcd_sevenseg_scan with an 8-cycle slot and a
// 2-cycle anti-ghost window (64-cycle frame).
module tb_bcd_sevenseg_scan;

    logic        clk;
    logic        reset;
    logic [31:0] data;
    logic        display_en;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    logic [7:0] dp_mask_tb = 8'b0101_0100;
    logic [6:0] pat [8];
    logic [7:0] lit;

    bcd_sevenseg_scan #(
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data      (data),
        .display_en(display_en),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_tick(frame_tick)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Hand model: expected {an,seg,dp} for slot s, cycle c of the slot,
    // digit pattern (active-high) and whether the digit is not blanked.
    function automatic logic [15:0] model(int s, int c, logic is_lit, logic [6:0] p, logic en);
        logic       on;
        logic [7:0] a;
        logic [6:0] g;
        logic       d;
        on = is_lit && (c >= 2) && en;
        a  = on ? ~(8'h01 << s) : 8'hFF;
        g  = on ? ~p : 7'h7F;
        d  = (on && dp_mask_tb[s]) ? 1'b0 : 1'b1;
        return {a, g, d};
    endfunction

    // Advances to the next frame_tick, bounded.
    task automatic wait_frame;
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_tick !== 1'b1 && n < 200);
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL frame_sync: frame_tick got %b after %0d cycles, expected 1", frame_tick, n);
        end
    endtask

    task automatic test_reset;
        int n;
        reset = 1'b1;
        data = 32'h0;
        display_en = 1'b1;
        repeat (3) tick();
        checks++;
        if ({an, seg, dp, frame_tick} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got an=%h seg=%h dp=%b ft=%b, expected an=ff seg=7f dp=1 ft=0", an, seg, dp, frame_tick);
        end
        reset = 1'b0;
        n = 0;
        do begin tick(); n++; end while (frame_tick !== 1'b1 && n < 200);
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL first_frame_tick: got %0d cycles, expected 64", n);
        end
        n = 0;
        do begin tick(); n++; end while (frame_tick !== 1'b1 && n < 200);
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL frame_period: got %0d cycles, expected 64", n);
        end
    endtask

    task automatic test_scan_digits;
        logic [15:0] e;
        int s, c;
        data = 32'h1234_5678;
        pat = '{7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
        lit = 8'hFF;
        wait_frame();
        for (int i = 1; i <= 64; i++) begin
            tick();
            s = (i - 1) / 8;
            c = (i - 1) % 8;
            e = model(s, c, lit[s], pat[s], 1'b1);
            checks++;
            if ({an, seg, dp} !== e) begin
                errors++;
                $display("FAIL scan_digits s%0d c%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b", s, c, an, seg, dp, e[15:8], e[7:1], e[0]);
            end
            checks++;
            if (frame_tick !== (i == 64)) begin
                errors++;
                $display("FAIL scan_frame_tick i%0d: got %b, expected %b", i, frame_tick, (i == 64));
            end
        end
    endtask

    task automatic test_leading_blank;
        logic [15:0] e;
        int s, c;
        data = 32'h0000_0012;
        pat = '{7'h5B, 7'h06, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        lit = 8'b0000_0111;
        wait_frame();
        for (int i = 1; i <= 128; i++) begin
            tick();
            s = ((i - 1) / 8) % 8;
            c = (i - 1) % 8;
            e = model(s, c, lit[s], pat[s], 1'b1);
            checks++;
            if ({an, seg, dp} !== e) begin
                errors++;
                $display("FAIL leading_blank s%0d c%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b", s, c, an, seg, dp, e[15:8], e[7:1], e[0]);
            end
        end
    endtask

    task automatic test_tear_free;
        logic [15:0] e;
        int s, c;
        data = 32'h0000_0011;
        pat = '{7'h06, 7'h06, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        lit = 8'b0000_0111;
        wait_frame();
        for (int i = 1; i <= 64; i++) begin
            tick();
            s = (i - 1) / 8;
            c = (i - 1) % 8;
            e = model(s, c, lit[s], pat[s], 1'b1);
            checks++;
            if ({an, seg, dp} !== e) begin
                errors++;
                $display("FAIL tear_old s%0d c%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b", s, c, an, seg, dp, e[15:8], e[7:1], e[0]);
            end
            if (s == 3 && c == 0) data = 32'h0000_0099;
        end
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL tear_boundary: frame_tick got %b, expected 1", frame_tick);
        end
        pat[0] = 7'h6F;
        pat[1] = 7'h6F;
        for (int i = 1; i <= 64; i++) begin
            tick();
            s = (i - 1) / 8;
            c = (i - 1) % 8;
            e = model(s, c, lit[s], pat[s], 1'b1);
            checks++;
            if ({an, seg, dp} !== e) begin
                errors++;
                $display("FAIL tear_new s%0d c%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b", s, c, an, seg, dp, e[15:8], e[7:1], e[0]);
            end
        end
    endtask

    task automatic test_invalid_and_enable;
        int n;
        int lit_seen;
        data = 32'h0000_000A;
        wait_frame();
        repeat (3) tick();
        checks++;
        if ({an, seg, dp} !== {8'hFE, 7'h3F, 1'b1}) begin
            errors++;
            $display("FAIL invalid_dash: got an=%h seg=%h dp=%b, expected an=fe seg=3f dp=1", an, seg, dp);
        end
        display_en = 1'b0;
        tick();
        checks++;
        if ({an, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
            errors++;
            $display("FAIL disable_off: got an=%h seg=%h dp=%b, expected an=ff seg=7f dp=1", an, seg, dp);
        end
        n = 0;
        do begin tick(); n++; end while (frame_tick !== 1'b1 && n < 200);
        checks++;
        if (n != 60) begin
            errors++;
            $display("FAIL disable_tick_phase: got %0d cycles, expected 60", n);
        end
        n = 0;
        lit_seen = 0;
        do begin
            tick();
            n++;
            if (an !== 8'hFF) lit_seen++;
        end while (frame_tick !== 1'b1 && n < 200);
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL disable_period: got %0d cycles, expected 64", n);
        end
        checks++;
        if (lit_seen != 0) begin
            errors++;
            $display("FAIL disable_dark: got %0d cycles with an!=ff, expected 0", lit_seen);
        end
        display_en = 1'b1;
    endtask

    task automatic test_mid_frame_reset;
        int n;
        data = 32'h1234_5678;
        wait_frame();
        repeat (44) tick();
        checks++;
        if ({an, seg, dp} !== {8'hDF, 7'h30, 1'b1}) begin
            errors++;
            $display("FAIL pre_reset_slot5: got an=%h seg=%h dp=%b, expected an=df seg=30 dp=1", an, seg, dp);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({an, seg, dp, frame_tick} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_values: got an=%h seg=%h dp=%b ft=%b, expected an=ff seg=7f dp=1 ft=0", an, seg, dp, frame_tick);
        end
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if ({an, seg, dp} !== {8'hFE, 7'h40, 1'b1}) begin
            errors++;
            $display("FAIL restart_slot0: got an=%h seg=%h dp=%b, expected an=fe seg=40 dp=1", an, seg, dp);
        end
        n = 3;
        do begin tick(); n++; end while (frame_tick !== 1'b1 && n < 200);
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL restart_frame_tick: got %0d cycles, expected 64", n);
        end
    endtask

    initial begin
        test_reset();
        test_scan_digits();
        test_leading_blank();
        test_tear_free();
        test_invalid_and_enable();
        test_mid_frame_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
